// File: rtl/fasta_writer_fsm.sv
// Streams one FASTA record (">SEQ\n" header, then sequence lines of LINE_LEN bases) from a sync-read RAM.
// Define FASTA_UPPERCASE_EN to fold lowercase sequence bytes to uppercase on output.
module fasta_writer_fsm #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_LEN   = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] seq_len,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [7:0]            ram_data,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StHdr   = 3'd1;
   localparam logic [2:0] StFetch = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StEmit  = 3'd4;
   localparam logic [2:0] StEol   = 3'd5;
   localparam logic [2:0] StDone  = 3'd6;

   localparam logic [7:0] LineLenW = 8'(LINE_LEN);

   logic [2:0]            state_q;
   logic [ADDR_WIDTH-1:0] len_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [7:0]            col_q;
   logic [7:0]            col_nxt;
   logic [2:0]            hdr_q;

   function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    hdr_byte = 8'h3E;
         3'd1:    hdr_byte = 8'h53;
         3'd2:    hdr_byte = 8'h45;
         3'd3:    hdr_byte = 8'h51;
         default: hdr_byte = 8'h0A;
      endcase
   endfunction

   function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef FASTA_UPPERCASE_EN
      conv = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
      conv = b;
`endif
   endfunction

   assign addr_nxt = addr_q + ADDR_WIDTH'(1);
   assign col_nxt  = col_q + 8'd1;
   // RAM address is presented directly from the counter so data lands in WAIT.
   assign ram_addr = addr_q;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         addr_q    <= '0;
         col_q     <= '0;
         hdr_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  len_q     <= seq_len;
                  addr_q    <= '0;
                  col_q     <= '0;
                  hdr_q     <= '0;
                  out_data  <= hdr_byte(3'd0);
                  out_valid <= 1'b1;
                  state_q   <= StHdr;
               end
            end
            StHdr: begin
               if (out_ready) begin
                  if (hdr_q == 3'd4) begin
                     out_valid <= 1'b0;
                     state_q   <= (len_q == '0) ? StDone : StFetch;
                  end else begin
                     hdr_q    <= hdr_q + 3'd1;
                     out_data <= hdr_byte(hdr_q + 3'd1);
                  end
               end
            end
            StFetch: state_q <= StWait;
            StWait: begin
               out_data  <= conv(ram_data);
               out_valid <= 1'b1;
               state_q   <= StEmit;
            end
            StEmit: begin
               if (out_ready) begin
                  addr_q <= addr_nxt;
                  col_q  <= col_nxt;
                  // Full line and end of sequence coinciding still yields a single newline.
                  if (col_nxt == LineLenW || addr_nxt == len_q) begin
                     out_data <= 8'h0A;
                     state_q  <= StEol;
                  end else begin
                     out_valid <= 1'b0;
                     state_q   <= StFetch;
                  end
               end
            end
            StEol: begin
               if (out_ready) begin
                  col_q     <= '0;
                  out_valid <= 1'b0;
                  state_q   <= (addr_q < len_q) ? StFetch : StDone;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fasta_writer_fsm.sv
// Self-checking bench for fasta_writer_fsm: vector table, directed corner cases, random records.
module tb_fasta_writer_fsm;

   localparam int AW = 16;
   localparam int LL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] seq_len = '0;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_data = 8'h00;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          done;

   fasta_writer_fsm #(.ADDR_WIDTH(AW), .LINE_LEN(LL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seq_len   (seq_len),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   always @(posedge clk) ram_data <= mem[ram_addr[7:0]];

   int   total = 0;
   int   bad = 0;
   byte  got[$];
   int   done_cnt = 0;
   bit   rnd_ready = 1'b0;
   bit   stall = 1'b0;
   logic [7:0] held = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Sink: collect handshaken bytes and verify the held byte during every stall.
   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
         end
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) done_cnt++;
         stall = out_valid && !out_ready;
         held  = out_data;
      end
   end

   function automatic logic [7:0] upcase(input logic [7:0] b);
`ifdef FASTA_UPPERCASE_EN
      if (b >= "a" && b <= "z") return b - 8'd32;
`endif
      return b;
   endfunction

   // Reference: header, then bases chunked into lines of LL, each chunk closed by one newline.
   function automatic void build_expected(input int len, output byte q[$]);
      string hdr = ">SEQ\n";
      q.delete();
      for (int i = 0; i < hdr.len(); i++) q.push_back(hdr[i]);
      for (int i = 0; i < len; i += LL) begin
         for (int j = i; j < i + LL && j < len; j++) q.push_back(upcase(mem[j]));
         q.push_back(8'h0A);
      end
   endfunction

   task automatic fill_pattern();
      byte bases [4] = '{"A", "C", "G", "T"};
      for (int i = 0; i < 256; i++) mem[i] = bases[i % 4];
   endtask

   task automatic run_record(input int len, input bit rnd, input bit hold, output int cycles);
      got.delete();
      done_cnt  = 0;
      rnd_ready = rnd;
      @(posedge clk); #1;
      seq_len = AW'(len);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = hold;
      seq_len = AW'(len + 3);
      check("busy_after_start", 32'(busy), 32'd1);
      cycles = 1;
      while (done_cnt == 0 && cycles < 3000) begin
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      check("record_finished", 32'(done_cnt != 0), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      rnd_ready = 1'b0;
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic compare_model(input int len);
      byte exp[$];
      build_expected(len, exp);
      check("stream_len", 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("byte[%0d] len=%0d", i, len), 32'(got[i]), 32'(exp[i]));
   endtask

   typedef struct {
      int len;
      bit rnd;
      bit hold;
      int exp_bytes;
   } vec_t;

   initial begin
      vec_t tbl [7];
      int   cyc;
      tbl[0] = '{len: 0, rnd: 0, hold: 0, exp_bytes: 5};
      tbl[1] = '{len: 6, rnd: 0, hold: 0, exp_bytes: 13};
      tbl[2] = '{len: 8, rnd: 0, hold: 0, exp_bytes: 15};
      tbl[3] = '{len: 6, rnd: 1, hold: 0, exp_bytes: 13};
      tbl[4] = '{len: 4, rnd: 0, hold: 1, exp_bytes: 10};
      tbl[5] = '{len: 9, rnd: 1, hold: 1, exp_bytes: 17};
      tbl[6] = '{len: 1, rnd: 0, hold: 0, exp_bytes: 7};

      fill_pattern();
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int t = 0; t < 7; t++) begin
         run_record(tbl[t].len, tbl[t].rnd, tbl[t].hold, cyc);
         check($sformatf("vec%0d_bytes", t), 32'(got.size()), 32'(tbl[t].exp_bytes));
         compare_model(tbl[t].len);
         if (!tbl[t].rnd)
            check($sformatf("vec%0d_throughput", t),
                  32'(cyc <= 8 + 3 * tbl[t].len + (tbl[t].len + LL - 1) / LL), 32'd1);
      end

      // Literal expected stream for the 6-base record.
      begin
         string s = ">SEQ\nACGT\nAC\n";
         run_record(6, 0, 0, cyc);
         check("lit_len", 32'(got.size()), 32'(s.len()));
         for (int i = 0; i < s.len() && i < got.size(); i++)
            check($sformatf("lit[%0d]", i), 32'(got[i]), 32'(s[i]));
      end

      // Case handling of sequence bytes.
      begin
         string s;
`ifdef FASTA_UPPERCASE_EN
         s = ">SEQ\nACGN\n";
`else
         s = ">SEQ\nacgn\n";
`endif
         mem[0] = "a"; mem[1] = "c"; mem[2] = "g"; mem[3] = "n";
         run_record(4, 0, 0, cyc);
         check("case_len", 32'(got.size()), 32'(s.len()));
         for (int i = 0; i < s.len() && i < got.size(); i++)
            check($sformatf("case[%0d]", i), 32'(got[i]), 32'(s[i]));
      end

      for (int r = 0; r < 8; r++) begin
         int len = $urandom_range(0, 30);
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
         run_record(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
         compare_model(len);
      end

      // Reset after three sequence bytes, then a fresh 2-base record.
      fill_pattern();
      mem[3] = "x";
      got.delete();
      rnd_ready = 1'b0;
      @(posedge clk); #1;
      seq_len = AW'(6);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int n = 0;
         while (got.size() < 8 && n < 500) begin
            @(posedge clk); #1;
            n++;
         end
         check("pre_reset_bytes", 32'(got.size() >= 8), 32'd1);
      end
      rst = 1'b1;
      #2;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_addr", 32'(ram_addr), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      got.delete();
      repeat (10) @(posedge clk);
      #1;
      check("no_bytes_after_rst", 32'(got.size()), 32'd0);
      run_record(2, 0, 0, cyc);
      check("restart_first", 32'(got.size() > 0 ? got[0] : 8'h00), 32'h3E);
      compare_model(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fasta_writer_fsm.md
FASTA_WRITER_FSM -- requirements
Module: fasta_writer_fsm

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the RAM address and of seq_len.
REQ-002 SHALL have parameter LINE_LEN, default 60: sequence characters per output line; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1: begin a new record when idle.
REQ-006 SHALL have port seq_len, input, ADDR_WIDTH: base count, sampled on an accepted start.
REQ-007 SHALL have port ram_addr, output, ADDR_WIDTH: read address into the sequence RAM written by fasta_to_sam_fsm.
REQ-008 SHALL have port ram_data, input, 8: RAM read data, valid one cycle after ram_addr is presented.
REQ-009 SHALL have port out_data, output, 8: ASCII output byte.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a byte.
REQ-011 SHALL have port out_ready, input, 1: sink accepts the byte when out_valid and out_ready are both 1.
REQ-012 SHALL have port busy, output, 1: high from an accepted start until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the record finishes.

Function
REQ-014 SHALL implement states IDLE, HDR, FETCH, WAIT, EMIT, EOL, DONE.
REQ-015 IDLE: start=1 latches seq_len, clears addr and column counters, and goes to HDR; busy rises next cycle.
REQ-016 HDR SHALL emit the five bytes '>' 'S' 'E' 'Q' 0x0A in order, one per handshake, then go to FETCH, or to DONE if seq_len=0.
REQ-017 FETCH SHALL drive ram_addr=addr for one cycle, then go to WAIT.
REQ-018 WAIT SHALL capture ram_data into the output register and go to EMIT with out_valid=1.
REQ-019 EMIT SHALL hold out_data and out_valid stable until the handshake completes.
REQ-020 On handshake, addr and column SHALL increment, and the next state SHALL be chosen as:
- EOL if column reaches LINE_LEN or addr reaches seq_len;
- else FETCH.
REQ-021 EOL SHALL emit 0x0A, then reset the column and go to FETCH if addr<seq_len, else to DONE.
REQ-022 A record SHALL contain exactly one 0x0A after the last base, never two in a row; this includes the case seq_len being a multiple of LINE_LEN.
REQ-023 DONE SHALL pulse done=1 for one cycle, deassert busy, and return to IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Sustained throughput SHALL be at least one byte per 3 cycles with out_ready held at 1.
REQ-026 out_valid SHALL never deassert without a handshake, except by reset.
REQ-027 Counters SHALL be ADDR_WIDTH wide with no wrap; seq_len = 2^ADDR_WIDTH-1 SHALL be supported.

Reset
REQ-028 rst=1 SHALL force the state to IDLE and set ram_addr=0, out_data=0, out_valid=0, busy=0, done=0, and all counters to 0, asynchronously.
REQ-029 Reset mid-record SHALL abandon the record without emitting further bytes; a start after release SHALL begin a fresh record.

Configuration
REQ-030 Macro FASTA_UPPERCASE_EN SHALL control case conversion of sequence bytes.
- Defined: bytes 0x61..0x7A from RAM are emitted minus 0x20, i.e. converted to uppercase.
- Undefined: RAM bytes are emitted unchanged.
- Header and newline bytes are unaffected in both cases.

Verification
REQ-031 seq_len=0, out_ready=1 -> output 3E 53 45 51 0A, then one done pulse.
REQ-032 LINE_LEN=4, seq_len=6, RAM="ACGTAC", out_ready=1 -> output ">SEQ\nACGT\nAC\n", then done.
REQ-033 LINE_LEN=4, seq_len=8 -> exactly two sequence lines, each ending with a single 0x0A; no empty line.
REQ-034 Random out_ready stalls (50%) on the REQ-032 record -> identical byte stream, and out_data stable during every stall.
REQ-035 rst pulsed after 3 sequence bytes, then a new start with seq_len=2 -> new stream begins with '>', and ram_addr restarts at 0.
REQ-036 FASTA_UPPERCASE_EN defined, RAM="acgn" -> "ACGN"; undefined -> "acgn".
